// File: rtl/cpu_params_pkg.sv
// Shared CPU configuration constants: predictor table sizes, BHT reset state
// and the register numbers treated as link registers by the return stack.
package cpu_params_pkg;

    localparam int         BHT_DEPTH_DEFAULT = 64;
    localparam int         RAS_DEPTH_DEFAULT = 4;
    localparam logic [1:0] BHT_INIT          = 2'b01;
    localparam logic [4:0] LINK_REG_RA       = 5'd1;
    localparam logic [4:0] LINK_REG_ALT      = 5'd5;

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared CPU decode types: branch operation class and adder operand selects.
package cpu_structs_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_COND = 3'd1,
        BR_JAL  = 3'd2,
        BR_JALR = 3'd3,
        BR_MRET = 3'd4
    } BR_OP_TYPE;

    typedef enum logic [1:0] {
        SEL_RS1 = 2'd0,
        SEL_IMM = 2'd1,
        SEL_PC  = 2'd2
    } BR_SEL_TYPE;

endpackage

// File: rtl/br_ras.sv
// Circular return address stack; a push when full overwrites the oldest entry,
// and a simultaneous pop+push on a non-empty stack replaces the top in place.
module br_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         valid
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && pop && cnt_q != '0) begin
            mem_d[ptr_q] = push_data;
        end else if (push) begin
            ptr_d        = ptr_q + PW'(1);
            mem_d[ptr_d] = push_data;
            if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (pop && cnt_q != '0) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid = (cnt_q != '0);
    assign top   = valid ? mem_q[ptr_q] : '0;

endmodule

// File: rtl/br_pred_fu.sv
// Branch functional unit: resolves branches/jumps/MRET, registers the result
// behind valid/ready, trains a bimodal BHT and (with BR_RAS_EN) a return stack.
module br_pred_fu
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int PC_SZ     = 32,
    parameter int RSZ       = 32,
    parameter int BHT_DEPTH = BHT_DEPTH_DEFAULT,
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT,
    parameter int ALIGN_C   = 0
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  BR_OP_TYPE        op,
    input  logic [2:0]       funct3,
    input  logic             ci,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  BR_SEL_TYPE       sel_x,
    input  BR_SEL_TYPE       sel_y,
    input  logic [RSZ-1:0]   rs1_data,
    input  logic [RSZ-1:0]   rs2_data,
    input  logic [RSZ-1:0]   imm,
    input  logic [PC_SZ-1:0] pc,
    input  logic [PC_SZ-1:0] mepc,
    input  logic             pred_taken,
    input  logic [PC_SZ-1:0] pred_pc,
    input  logic [PC_SZ-1:0] fetch_pc,
    output logic             fetch_pred_taken,
    output logic [PC_SZ-1:0] ras_top,
    output logic             ras_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mis,
    output logic             out_mispredict,
    output logic [PC_SZ-1:0] out_br_pc,
    output logic [PC_SZ-1:0] out_no_br_pc
);
    localparam int IDX = $clog2(BHT_DEPTH);

    logic [PC_SZ-1:0] x, y, addxy, no_br_pc, br_pc;
    logic             cond, taken, mis, mispredict, accept;
    logic [IDX-1:0]   upd_idx;

    logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
    logic             out_valid_q, out_valid_d;
    logic             out_taken_q, out_taken_d;
    logic             out_mis_q, out_mis_d;
    logic             out_mispredict_q, out_mispredict_d;
    logic [PC_SZ-1:0] out_br_pc_q, out_br_pc_d;
    logic [PC_SZ-1:0] out_no_br_pc_q, out_no_br_pc_d;

    always_comb begin
        case (sel_x)
            SEL_RS1: x = PC_SZ'(rs1_data);
            SEL_IMM: x = PC_SZ'(imm);
            default: x = pc;
        endcase
        case (sel_y)
            SEL_RS1: y = PC_SZ'(rs1_data);
            SEL_IMM: y = PC_SZ'(imm);
            default: y = pc;
        endcase
        addxy    = x + y;
        no_br_pc = pc + (ci ? PC_SZ'(2) : PC_SZ'(4));

        case (funct3)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond = (rs1_data <  rs2_data);
            3'b111:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase

        taken = 1'b0;
        br_pc = no_br_pc;
        case (op)
            BR_COND: begin taken = cond; br_pc = cond ? addxy : no_br_pc; end
            BR_JAL:  begin taken = 1'b1; br_pc = addxy; end
            BR_JALR: begin taken = 1'b1; br_pc = {addxy[PC_SZ-1:1], 1'b0}; end
            BR_MRET: begin taken = 1'b1; br_pc = mepc; end
            default: ;
        endcase

        mis        = (ALIGN_C == 1) ? br_pc[0] : (br_pc[1:0] != 2'b00);
        mispredict = (taken != pred_taken) | (taken & (br_pc != pred_pc));
    end

    assign in_ready = !out_valid_q | out_ready;
    assign accept   = in_valid & in_ready & !flush_in;
    assign upd_idx  = pc[IDX+1:2];

    // The lookup sees the pre-update counter; same-cycle writes are not forwarded.
    assign fetch_pred_taken = bht_q[fetch_pc[IDX+1:2]][1];

    always_comb begin
        bht_d = bht_q;
        if (accept && op == BR_COND) begin
            if (taken && bht_q[upd_idx] != 2'b11)
                bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
            else if (!taken && bht_q[upd_idx] != 2'b00)
                bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
        end
    end

    always_comb begin
        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_mis_d        = out_mis_q;
        out_mispredict_d = out_mispredict_q;
        out_br_pc_d      = out_br_pc_q;
        out_no_br_pc_d   = out_no_br_pc_q;
        if (flush_in) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d      = 1'b1;
            out_taken_d      = taken;
            out_mis_d        = mis;
            out_mispredict_d = mispredict;
            out_br_pc_d      = br_pc;
            out_no_br_pc_d   = no_br_pc;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            bht_q            <= {BHT_DEPTH{BHT_INIT}};
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_mis_q        <= 1'b0;
            out_mispredict_q <= 1'b0;
            out_br_pc_q      <= '0;
            out_no_br_pc_q   <= '0;
        end else begin
            bht_q            <= bht_d;
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_mis_q        <= out_mis_d;
            out_mispredict_q <= out_mispredict_d;
            out_br_pc_q      <= out_br_pc_d;
            out_no_br_pc_q   <= out_no_br_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = out_taken_q;
    assign out_mis        = out_mis_q;
    assign out_mispredict = out_mispredict_q;
    assign out_br_pc      = out_br_pc_q;
    assign out_no_br_pc   = out_no_br_pc_q;

    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{fetch_pc[PC_SZ-1:IDX+2], fetch_pc[1:0]};

`ifdef BR_RAS_EN
    logic link_rd, link_rs1, ras_push, ras_pop;
    assign link_rd  = (rd == LINK_REG_RA) || (rd == LINK_REG_ALT);
    assign link_rs1 = (rs1 == LINK_REG_RA) || (rs1 == LINK_REG_ALT);
    assign ras_push = accept && (op == BR_JAL || op == BR_JALR) && link_rd;
    assign ras_pop  = accept && (op == BR_JALR) && link_rs1;

    br_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_SZ)
    ) u_ras (
        .clk       (clk_in),
        .rst       (reset_in),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (no_br_pc),
        .top       (ras_top),
        .valid     (ras_valid)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_regs;
    assign unused_ras_regs = ^{rd, rs1};
    assign ras_top   = '0;
    assign ras_valid = 1'b0;
`endif

endmodule

// File: tb/tb_br_pred_fu.sv
// Directed self-checking bench for br_pred_fu; the return-stack section is
// exercised only when BR_RAS_EN is defined.
module tb_br_pred_fu;
    import cpu_structs_pkg::*;

    logic        clk_in = 1'b0;
    logic        reset_in, flush_in, in_valid, in_ready, ci;
    BR_OP_TYPE   op;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1;
    BR_SEL_TYPE  sel_x, sel_y;
    logic [31:0] rs1_data, rs2_data, imm, pc, mepc, pred_pc, fetch_pc;
    logic        pred_taken, fetch_pred_taken, ras_valid, out_valid, out_ready;
    logic        out_taken, out_mis, out_mispredict;
    logic [31:0] ras_top, out_br_pc, out_no_br_pc;

    int n_tests  = 0;
    int n_failed = 0;

    br_pred_fu dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .flush_in         (flush_in),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .op               (op),
        .funct3           (funct3),
        .ci               (ci),
        .rd               (rd),
        .rs1              (rs1),
        .sel_x            (sel_x),
        .sel_y            (sel_y),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .imm              (imm),
        .pc               (pc),
        .mepc             (mepc),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .fetch_pc         (fetch_pc),
        .fetch_pred_taken (fetch_pred_taken),
        .ras_top          (ras_top),
        .ras_valid        (ras_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_taken        (out_taken),
        .out_mis          (out_mis),
        .out_mispredict   (out_mispredict),
        .out_br_pc        (out_br_pc),
        .out_no_br_pc     (out_no_br_pc)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input BR_OP_TYPE o, input logic [2:0] f3, input logic c,
                                 input BR_SEL_TYPE sx, input BR_SEL_TYPE sy,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] p,
                                 input logic pt, input logic [31:0] ppc);
        op = o; funct3 = f3; ci = c; sel_x = sx; sel_y = sy;
        rs1_data = a; rs2_data = b; imm = im; pc = p;
        pred_taken = pt; pred_pc = ppc; rd = 5'd0; rs1 = 5'd0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic acceptOne();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic checkPred(input string tag, input logic [31:0] addr, input logic expected);
        fetch_pc = addr;
        #1;
        checkOutput(tag, {31'd0, fetch_pred_taken}, {31'd0, expected});
    endtask

    initial begin
        reset_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mepc = 32'h8000_0000; fetch_pc = 32'h100;
        applyStimulus(BR_NONE, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 0, 0, 1'b0, 0);
        #12;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_br_pc", out_br_pc, 32'd0);
        checkOutput("rst_ras_valid", {31'd0, ras_valid}, 32'd0);
        checkOutput("rst_ras_top", ras_top, 32'd0);
        checkPred("rst_bht", 32'h100, 1'b0);
        reset_in = 1'b0;

        // beq taken, counter 01 -> 10
        applyStimulus(BR_COND, 3'b000, 1'b0, SEL_PC, SEL_IMM, 5, 5, 32'h20, 32'h100, 1'b0, 0);
        acceptOne();
        checkOutput("beq_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("beq_taken", {31'd0, out_taken}, 32'd1);
        checkOutput("beq_br_pc", out_br_pc, 32'h120);
        checkOutput("beq_no_br_pc", out_no_br_pc, 32'h104);
        checkOutput("beq_mispredict", {31'd0, out_mispredict}, 32'd1);
        checkOutput("beq_mis", {31'd0, out_mis}, 32'd0);
        checkPred("bht_after_t1", 32'h100, 1'b1);
        checkPred("bht_other_idx", 32'h104, 1'b0);
        acceptOne();
        acceptOne();
        checkOutput("beq_idle_drop", {31'd0, out_valid}, 32'd1);

        // not-taken run from 11 down to saturation at 00
        applyStimulus(BR_COND, 3'b000, 1'b0, SEL_PC, SEL_IMM, 5, 6, 32'h20, 32'h100, 1'b0, 0);
        acceptOne();
        checkOutput("nt_taken", {31'd0, out_taken}, 32'd0);
        checkOutput("nt_br_pc", out_br_pc, 32'h104);
        checkOutput("nt_mispredict", {31'd0, out_mispredict}, 32'd0);
        checkPred("bht_11_to_10", 32'h100, 1'b1);
        acceptOne();
        checkPred("bht_10_to_01", 32'h100, 1'b0);
        acceptOne();
        acceptOne();
        applyStimulus(BR_COND, 3'b000, 1'b0, SEL_PC, SEL_IMM, 5, 5, 32'h20, 32'h100, 1'b1, 32'h120);
        acceptOne();
        checkOutput("t_correct_pred", {31'd0, out_mispredict}, 32'd0);
        checkPred("bht_sat0_then_01", 32'h100, 1'b0);
        acceptOne();
        checkPred("bht_01_to_10", 32'h100, 1'b1);

        step();
        checkOutput("idle_no_valid", {31'd0, out_valid}, 32'd0);

        // backpressure: second op waits, first result holds
        out_ready = 1'b0;
        applyStimulus(BR_JAL, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 32'h10, 32'h400, 1'b1, 32'h410);
        in_valid = 1'b1;
        step();
        checkOutput("bp_a_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_a_pc", out_br_pc, 32'h410);
        checkOutput("bp_a_mispredict", {31'd0, out_mispredict}, 32'd0);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(BR_JAL, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 32'h8, 32'h500, 1'b0, 0);
        step();
        checkOutput("bp_hold1_pc", out_br_pc, 32'h410);
        checkOutput("bp_hold1_nbr", out_no_br_pc, 32'h404);
        step();
        checkOutput("bp_hold2_pc", out_br_pc, 32'h410);
        checkOutput("bp_hold2_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        checkOutput("bp_b_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_b_pc", out_br_pc, 32'h508);
        checkOutput("bp_b_mispredict", {31'd0, out_mispredict}, 32'd1);
        step();
        checkOutput("bp_drain", {31'd0, out_valid}, 32'd0);

        // flush blocks accept and BHT update
        applyStimulus(BR_COND, 3'b000, 1'b0, SEL_PC, SEL_IMM, 9, 9, 32'h40, 32'h104, 1'b0, 0);
        flush_in = 1'b1;
        acceptOne();
        flush_in = 1'b0;
        checkOutput("flush_no_valid", {31'd0, out_valid}, 32'd0);
        checkPred("flush_bht_same", 32'h104, 1'b0);
        acceptOne();
        checkOutput("noflush_valid", {31'd0, out_valid}, 32'd1);
        checkPred("noflush_bht_up", 32'h104, 1'b1);
        out_ready = 1'b0;
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        out_ready = 1'b1;
        checkOutput("flush_clears_pending", {31'd0, out_valid}, 32'd0);

        // JALR target alignment, compressed not-taken bne, signed/unsigned compares, MRET
        applyStimulus(BR_JALR, 3'b000, 1'b0, SEL_RS1, SEL_IMM, 32'h103, 32'h0, 32'h0, 32'h50, 1'b1, 32'h102);
        acceptOne();
        checkOutput("jalr_pc", out_br_pc, 32'h102);
        checkOutput("jalr_mis", {31'd0, out_mis}, 32'd1);
        checkOutput("jalr_mispredict", {31'd0, out_mispredict}, 32'd0);
        applyStimulus(BR_COND, 3'b001, 1'b1, SEL_PC, SEL_IMM, 7, 7, 32'h40, 32'h10, 1'b1, 32'h50);
        acceptOne();
        checkOutput("cbne_taken", {31'd0, out_taken}, 32'd0);
        checkOutput("cbne_br_pc", out_br_pc, 32'h12);
        checkOutput("cbne_mis", {31'd0, out_mis}, 32'd1);
        checkOutput("cbne_mispredict", {31'd0, out_mispredict}, 32'd1);
        applyStimulus(BR_COND, 3'b100, 1'b0, SEL_PC, SEL_IMM, 32'hFFFF_FFFF, 1, 32'h40, 32'h20, 1'b1, 32'h60);
        acceptOne();
        checkOutput("blt_signed_pc", out_br_pc, 32'h60);
        checkOutput("blt_mispredict", {31'd0, out_mispredict}, 32'd0);
        applyStimulus(BR_COND, 3'b110, 1'b0, SEL_PC, SEL_IMM, 32'hFFFF_FFFF, 1, 32'h40, 32'h20, 1'b1, 32'h60);
        acceptOne();
        checkOutput("bltu_pc", out_br_pc, 32'h24);
        checkOutput("bltu_taken", {31'd0, out_taken}, 32'd0);
        applyStimulus(BR_MRET, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 0, 32'h70, 1'b1, 32'h8000_0004);
        acceptOne();
        checkOutput("mret_pc", out_br_pc, 32'h8000_0000);
        checkOutput("mret_mispredict", {31'd0, out_mispredict}, 32'd1);

`ifdef BR_RAS_EN
        applyStimulus(BR_JAL, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 32'h40, 32'h200, 1'b1, 32'h240);
        rd = 5'd1;
        acceptOne();
        checkOutput("ras_push_top", ras_top, 32'h204);
        checkOutput("ras_push_valid", {31'd0, ras_valid}, 32'd1);
        applyStimulus(BR_JALR, 3'b000, 1'b0, SEL_RS1, SEL_IMM, 32'h204, 0, 0, 32'h300, 1'b1, 32'h204);
        rs1 = 5'd1;
        acceptOne();
        checkOutput("ras_pop_valid", {31'd0, ras_valid}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(BR_JAL, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 32'h40, i * 32'h1000, 1'b1, 0);
            rd = 5'd1;
            acceptOne();
        end
        checkOutput("ras_full_top", ras_top, 32'h5004);
        for (int i = 4; i >= 1; i--) begin
            applyStimulus(BR_JALR, 3'b000, 1'b0, SEL_RS1, SEL_IMM, 0, 0, 0, 32'h300, 1'b1, 0);
            rs1 = 5'd1;
            acceptOne();
            if (i > 1) checkOutput("ras_drain_top", ras_top, i * 32'h1000 + 32'h4);
        end
        checkOutput("ras_drained", {31'd0, ras_valid}, 32'd0);
`else
        applyStimulus(BR_JAL, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 32'h40, 32'h200, 1'b1, 32'h240);
        rd = 5'd1;
        acceptOne();
        checkOutput("noras_valid", {31'd0, ras_valid}, 32'd0);
        checkOutput("noras_top", ras_top, 32'd0);
        checkOutput("noras_jal_pc", out_br_pc, 32'h240);
`endif

        // asynchronous reset discards a pending result and restores the BHT
        out_ready = 1'b0;
        applyStimulus(BR_JAL, 3'b000, 1'b0, SEL_PC, SEL_IMM, 0, 0, 32'h4, 32'h600, 1'b0, 0);
        acceptOne();
        checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_in = 1'b1;
        #1;
        checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_rst_pc", out_br_pc, 32'd0);
        checkPred("async_rst_bht", 32'h100, 1'b0);
        reset_in = 1'b0;
        out_ready = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/br_pred_fu.md
# br_pred_fu

Parametrised branch functional unit with dynamic prediction support, used in the EXE stage. It resolves conditional branches, JAL/JALR and xRET, and registers the result behind a valid/ready handshake. It also maintains a bimodal branch history table (BHT) and an optional return address stack (RAS), which the fetch stage reads. The unit flags a mispredict whenever the resolved outcome differs from the prediction fetch carried down the pipe.

## Interface
- `PC_SZ`, default 32: PC and target width.
- `RSZ`, default 32: register data width.
- `BHT_DEPTH`, default 64: number of 2-bit counters; must be a power of 2, minimum 4.
- `RAS_DEPTH`, default 4: RAS entries; must be a power of 2.
- `ALIGN_C`, default 0: 1 means 2-byte instruction alignment, 0 means 4-byte.
- `clk_in`, in, 1: the single clock.
- `reset_in`, in, 1: asynchronous, active-high reset.
- `flush_in`, in, 1: pipeline flush.
- `in_valid`, in, 1 / `in_ready`, out, 1: operand handshake.
- `op`, in, `BR_OP_TYPE`; `funct3`, in, 3; `ci`, in, 1; `rd`, in, 5; `rs1`, in, 5.
- `sel_x`, `sel_y`, in, `BR_SEL_TYPE`: adder operand selects (RS1, IMM, PC).
- `rs1_data`, `rs2_data`, in, RSZ; `imm`, in, RSZ; `pc`, in, PC_SZ; `mepc`, in, PC_SZ.
- `pred_taken`, in, 1; `pred_pc`, in, PC_SZ: the prediction made by fetch.
- `fetch_pc`, in, PC_SZ; `fetch_pred_taken`, out, 1: BHT lookup.
- `ras_top`, out, PC_SZ; `ras_valid`, out, 1: RAS lookup.
- `out_valid`, out, 1 / `out_ready`, in, 1: result handshake.
- `out_taken`, `out_mis`, `out_mispredict`, out, 1 each.
- `out_br_pc`, `out_no_br_pc`, out, PC_SZ.

## Operation
- Operand muxes, the x+y adder, no_br_pc (pc+2 when `ci`, otherwise pc+4) and the taken/br_pc rules:
  - beq/bne/blt/bge/bltu/bgeu and c.beqz/c.bnez: select between addxy and no_br_pc on the branch condition.
  - JAL: addxy.
  - JALR: addxy with bit 0 cleared.
  - MRET: mepc.
- `mis`: br_pc[0] when ALIGN_C=1; br_pc[1:0]!=0 when ALIGN_C=0.
- `mispredict` = (taken != pred_taken) | (taken & (br_pc != pred_pc)).
- Accept occurs when `in_valid & in_ready & !flush_in`.
  - On accept the result is written into the single output register.
  - For conditional ops, the BHT entry pc[IDX+1:2] (IDX = log2 BHT_DEPTH) updates as a saturating counter: +1 if taken, −1 if not, clamped to 0..3.
- `fetch_pred_taken` = counter[fetch_pc index][1], read combinationally. A same-cycle update to the same index is not forwarded; the lookup returns the old value.

## Timing
- Latency is 1 cycle from accept to `out_valid`.
- `in_ready` = !out_valid | out_ready; back-to-back accepts sustain full throughput.
- Outputs hold stable while `out_valid & !out_ready`.
- `flush_in`:
  - Clears `out_valid` next cycle.
  - Blocks accept in the same cycle, with no BHT/RAS update.
  - Has priority over all other events.
- Reset values:
  - `out_valid`=0; all `out_*` data = 0.
  - Every BHT counter = 2'b01 (weakly not-taken).
  - RAS empty, so `ras_valid`=0 and `ras_top`=0.
  - `in_ready`=1.
- Reset is asynchronous and takes effect mid-transaction: pending results are discarded.

## Configuration
- `BR_RAS_EN` defined: RAS present. Rules apply on accept; link = x1 or x5.
  - JAL/JALR with link `rd`: push no_br_pc.
  - JALR with link `rs1` and non-link `rd`: pop.
  - Both conditions true: pop then push (top replaced, count unchanged).
  - Push when full: wraps and overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change.
  - `ras_top` always reflects the current top entry.
- `BR_RAS_EN` not defined: no RAS storage; `ras_valid`=0 and `ras_top`=0. JALR still resolves and reports mispredict normally.

## Structure
- `BR_OP_TYPE` and `BR_SEL_TYPE` already live in `cpu_structs_pkg`.
- Add to `cpu_params_pkg`:
  - `BHT_DEPTH` and `RAS_DEPTH` defaults.
  - A `BHT_INIT` constant (2'b01).
  - The link-register numbers.
- One sub-module, `br_ras`: a circular stack with push/pop/top/valid, instantiated only under `BR_RAS_EN`.

## Test plan
- Reset, then beq with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 → out_taken=1, br_pc=0x120, mispredict=1; BHT[0x100] goes from 01 to 10.
- Same beq accepted three times taken, then fetch_pc=0x100 → fetch_pred_taken=1. Then three not-taken → counter reaches 00 and stays there after a fourth not-taken.
- Hold out_ready=0 with in_valid=1 → in_ready=0 on the second cycle and outputs hold stable. Release → both results are delivered in order, one per cycle.
- flush_in asserted together with in_valid → no out_valid next cycle and the BHT is unchanged.
- With BR_RAS_EN: JAL rd=x1 at pc=0x200 pushes 0x204 (ras_top=0x204). JALR rs1=x1, rd=x0 pops it. Five pushes with RAS_DEPTH=4 → the oldest entry is lost and four pops drain to ras_valid=0.
- ALIGN_C=0 with JALR target 0x102 → mis=1; bne at pc=0x10 with ci=1 not taken → br_pc=0x12.
